// File: rtl/echo_dac_fifo.sv
// echo_dac_fifo: per-channel Q2.2 gain and 16-bit saturation on stereo echo
// frames, followed by an 8-deep first-word-fall-through FIFO that the DAC
// transmitter drains through a valid/ready handshake.
module echo_dac_fifo #(
  parameter int SINGLE_DAC_WIDTH = 19,
  parameter int DAC_DATA_WIDTH   = 38,
  parameter int OUT_WIDTH        = 16,
  parameter int GAIN_WIDTH       = 4,
  parameter int ADDR_WIDTH       = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ce,
  input  logic [DAC_DATA_WIDTH-1:0] Echo_Out,
  input  logic                      echo_Done,
  input  logic [GAIN_WIDTH-1:0]     gain_left,
  input  logic [GAIN_WIDTH-1:0]     gain_right,
  output logic [2*OUT_WIDTH-1:0]    dac_dout,
  output logic                      dac_valid,
  input  logic                      dac_ready,
  output logic [ADDR_WIDTH:0]       fifo_level,
  output logic                      overflow,
  output logic                      clip
);

  // Product is wide enough for a full-scale sample times the largest gain
  // (the gain is zero-extended by one bit so it multiplies as a positive number).
  localparam int PROD_WIDTH = SINGLE_DAC_WIDTH + GAIN_WIDTH + 1;
  localparam int FRAC_BITS  = 2;
  localparam int DEPTH      = 2 ** ADDR_WIDTH;
  localparam int WORD_WIDTH = 2 * OUT_WIDTH;

  localparam logic signed [PROD_WIDTH-1:0] SAT_MAX = PROD_WIDTH'((2 ** (OUT_WIDTH - 1)) - 1);
  localparam logic signed [PROD_WIDTH-1:0] SAT_MIN = PROD_WIDTH'(-(2 ** (OUT_WIDTH - 1)));
  localparam logic [ADDR_WIDTH:0]          FULL_LEVEL = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]          ONE_LEVEL  = (ADDR_WIDTH + 1)'(1);

  // Drop the Q2.2 fraction (arithmetic shift floors toward -inf) and clamp to
  // the signed output range; the top bit of the result flags a clamp.
  function automatic logic [OUT_WIDTH:0] saturate(input logic signed [PROD_WIDTH-1:0] prod);
    logic signed [PROD_WIDTH-1:0] shifted;
    shifted = prod >>> FRAC_BITS;
    if (shifted > SAT_MAX) begin
      return {1'b1, SAT_MAX[OUT_WIDTH-1:0]};
    end else if (shifted < SAT_MIN) begin
      return {1'b1, SAT_MIN[OUT_WIDTH-1:0]};
    end else begin
      return {1'b0, shifted[OUT_WIDTH-1:0]};
    end
  endfunction

  // ---------------------------------------------------------------------
  // Stage 1: sign-extend each channel and multiply by its gain
  // ---------------------------------------------------------------------
  logic [SINGLE_DAC_WIDTH-1:0]  in_left;
  logic [SINGLE_DAC_WIDTH-1:0]  in_right;
  logic signed [PROD_WIDTH-1:0] left_ext;
  logic signed [PROD_WIDTH-1:0] right_ext;
  logic signed [PROD_WIDTH-1:0] gain_left_ext;
  logic signed [PROD_WIDTH-1:0] gain_right_ext;
  logic signed [PROD_WIDTH-1:0] prod_left_next;
  logic signed [PROD_WIDTH-1:0] prod_right_next;

  logic                         s1_v;
  logic signed [PROD_WIDTH-1:0] prod_left;
  logic signed [PROD_WIDTH-1:0] prod_right;

  assign in_left  = Echo_Out[DAC_DATA_WIDTH-1:SINGLE_DAC_WIDTH];
  assign in_right = Echo_Out[SINGLE_DAC_WIDTH-1:0];

  assign left_ext       = {{(PROD_WIDTH - SINGLE_DAC_WIDTH){in_left[SINGLE_DAC_WIDTH-1]}}, in_left};
  assign right_ext      = {{(PROD_WIDTH - SINGLE_DAC_WIDTH){in_right[SINGLE_DAC_WIDTH-1]}}, in_right};
  assign gain_left_ext  = {{(PROD_WIDTH - GAIN_WIDTH){1'b0}}, gain_left};
  assign gain_right_ext = {{(PROD_WIDTH - GAIN_WIDTH){1'b0}}, gain_right};

  assign prod_left_next  = left_ext * gain_left_ext;
  assign prod_right_next = right_ext * gain_right_ext;

  // Capture products on the strobe; the stage freezes entirely while ce is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v       <= 1'b0;
      prod_left  <= '0;
      prod_right <= '0;
    end else if (ce) begin
      s1_v <= echo_Done;
      if (echo_Done) begin
        prod_left  <= prod_left_next;
        prod_right <= prod_right_next;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Stage 2: scale back, saturate and pack {left16, right16}
  // ---------------------------------------------------------------------
  logic [OUT_WIDTH:0]  sat_left;
  logic [OUT_WIDTH:0]  sat_right;

  logic                  s2_v;
  logic [WORD_WIDTH-1:0] s2_word;
  logic                  s2_clip;

  assign sat_left  = saturate(prod_left);
  assign sat_right = saturate(prod_right);

  // Register the packed word with its clamp flag; holds while ce is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_v    <= 1'b0;
      s2_word <= '0;
      s2_clip <= 1'b0;
    end else if (ce) begin
      s2_v    <= s1_v;
      s2_word <= {sat_left[OUT_WIDTH-1:0], sat_right[OUT_WIDTH-1:0]};
      s2_clip <= sat_left[OUT_WIDTH] | sat_right[OUT_WIDTH];
    end
  end

  // ---------------------------------------------------------------------
  // FIFO: circular buffer with an exact occupancy count
  // ---------------------------------------------------------------------
  logic [WORD_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr_next;
  logic                  full;
  logic                  pop;
  logic                  wr_req;
  logic                  wr_en;
  logic [WORD_WIDTH-1:0] dout_next;

  assign dac_valid   = (fifo_level != '0);
  assign full        = (fifo_level == FULL_LEVEL);
  assign pop         = dac_valid && dac_ready;
  assign wr_req      = ce && s2_v;
  // A pop on the same edge frees a slot, so a full FIFO can still accept.
  assign wr_en       = wr_req && (!full || pop);
  assign rd_ptr_next = rd_ptr + ADDR_WIDTH'(1);

  // Storage array; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= s2_word;
    end
  end

  // Choose the next head word: the entry behind the popped one, or the frame
  // being written when it lands in an otherwise empty FIFO; else hold.
  always_comb begin
    dout_next = dac_dout;
    if (pop) begin
      if (fifo_level > ONE_LEVEL) begin
        dout_next = mem[rd_ptr_next];
      end else if (wr_en) begin
        dout_next = s2_word;
      end
    end else if (!dac_valid && wr_en) begin
      dout_next = s2_word;
    end
  end

  // Pointer, occupancy, head register and status flag updates.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      dac_dout   <= '0;
      overflow   <= 1'b0;
      clip       <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr_next;
      end
      case ({wr_en, pop})
        2'b10:   fifo_level <= fifo_level + ONE_LEVEL;
        2'b01:   fifo_level <= fifo_level - ONE_LEVEL;
        default: fifo_level <= fifo_level;
      endcase
      if (wr_req && !wr_en) begin
        overflow <= 1'b1;
      end
      clip     <= wr_en && s2_clip;
      dac_dout <= dout_next;
    end
  end

endmodule

// File: doc/echo_dac_fifo.md
Name: echo_dac_fifo

Overview:
- Stage directly downstream of the stereo echo block.
- Captures each 38-bit echo frame ({left 19b, right 19b}) on the echo done strobe, applies a per-channel Q2.2 gain and saturates each channel to 16-bit signed.
- Buffers the packed 32-bit frames in a small FIFO that the DAC/I2S transmitter drains with a valid/ready handshake, decoupling echo timing from DAC timing.

Parameters:
- SINGLE_DAC_WIDTH, 19, per-channel input width (signed two's complement)
- DAC_DATA_WIDTH, 38, packed input width = 2*SINGLE_DAC_WIDTH
- OUT_WIDTH, 16, per-channel output width (signed)
- GAIN_WIDTH, 4, unsigned gain width, Q2.2 format (4'b0100 = 1.0)
- ADDR_WIDTH, 3, FIFO address width; depth = 2**ADDR_WIDTH = 8

Ports:
- clk  in  1  system clock, all logic rising-edge
- rst  in  1  synchronous reset, active-high
- ce  in  1  high-level enable for input capture and gain pipeline
- Echo_Out  in  DAC_DATA_WIDTH  {left[37:19], right[18:0]}, signed per channel
- echo_Done  in  1  one-cycle strobe, Echo_Out valid this cycle
- gain_left  in  GAIN_WIDTH  left gain, Q2.2 unsigned
- gain_right  in  GAIN_WIDTH  right gain, Q2.2 unsigned
- dac_dout  out  2*OUT_WIDTH  {left16, right16}, head of FIFO
- dac_valid  out  1  FIFO non-empty
- dac_ready  in  1  consumer accepts dac_dout when dac_valid&&dac_ready
- fifo_level  out  ADDR_WIDTH+1  current occupancy, 0..8
- overflow  out  1  sticky: a frame was dropped because FIFO full
- clip  out  1  one-cycle pulse when either channel of a written frame saturated

Behaviour:
- Reset (rst=1 at clock edge): pipeline valid bits cleared, FIFO pointers/level = 0, dac_dout = 0, dac_valid = 0, overflow = 0, clip = 0. Reset overrides ce and all handshakes; in-flight frames are discarded.
- Stage 1 (ce=1, echo_Done=1): register prodL = sext(left)*{1'b0,gain_left}, prodR likewise; 24-bit signed; gains sampled on the same edge as Echo_Out. Valid bit s1_v <= echo_Done.
- Stage 2 (ce=1): shift right arithmetic by 2 (floor toward -inf), saturate to [-32768, 32767]; register packed word and s2_v <= s1_v; clip flag computed here.
- FIFO write: when s2_v=1 and ce=1 on the following edge. If full and no simultaneous read: frame dropped, overflow <= 1, clip not asserted for dropped frame.
- Latency: echo_Done at edge N -> stage1 N+1 -> stage2 N+2 -> written N+3; with FIFO empty, dac_valid=1 and dac_dout valid after edge N+3.
- ce=0: stages hold contents and valid bits, echo_Done ignored, no FIFO write. Read side operates regardless of ce.
- Read: dac_valid = (level != 0); pop on dac_valid && dac_ready; dac_dout is registered head word, updates on the edge after a pop (first-word-fall-through). dac_ready while empty: no effect, dac_dout holds last value.
- Simultaneous write+read: at full, write accepted (read frees slot), level unchanged, no overflow; at empty, write only (no read since dac_valid=0).
- Pointers wrap modulo 8; level tracks exact count 0..8.
- Back-to-back echo_Done every cycle supported (full throughput 1 frame/cycle).
- clip: pulses 1 cycle on the write edge of any frame where either channel clamped.

Test Plan:
- Unity pass-through: left=1000, right=-1000, gains=4'b0100, echo_Done at N -> dac_valid at N+3, dac_dout=32'h03E8_FC18, clip=0.
- Saturation: left=100000, right=-100000, gains=4 -> dac_dout=32'h7FFF_8000, clip pulse 1 cycle, overflow=0.
- Fractional gain: left=1001, right=-1001, gains=4'b0010 (0.5) -> left=500 (16'h01F4), right=-501 (16'hFE0B); gain 0 -> 32'h0000_0000.
- Fill/overflow: dac_ready=0, 9 strobes values 1..9 -> level=8, overflow=1 sticky; then dac_ready=1 drains 1..8 in order, level->0, dac_valid=0, dac_dout holds frame 8.
- Full with simultaneous read: level=8, strobe timed so write edge coincides with pop -> level stays 8, overflow stays 0, new frame appears last.
- ce/reset: ce=0 for 5 cycles with frame in stage1 -> no write, resumes with +5 cycle latency; rst mid-pipeline with level=3 -> all outputs 0 next cycle, in-flight frame never emerges.
